// File: rtl/gpio_host_seq.sv
// gpio_host_seq: hardware host driving the convolver GPIO control word and readback.
// Define HOST_SEQ_FMT_CHECK_EN to build the sticky readback format check on o_err.
module gpio_host_seq #(
    parameter int GPIO_D     = 32,
    parameter int NB_ADDRESS = 10,
    parameter int RAM_WIDTH  = 13,
    parameter int M_LEN      = 3,
    parameter int RST_CYCLES = 4,
    parameter int STREAM_LEN = 38,
    parameter int READ_LEN   = 32,
    parameter int READ_LAT   = 2
) (
    input  logic                 CLK100MHZ,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic [GPIO_D-1:0]    o_gpio_o,
    input  logic [GPIO_D-1:0]    i_gpio_i,
    output logic [RAM_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int CW = 16;
    localparam int AW = NB_ADDRESS + 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] KLOAD_LAST  = CW'(M_LEN - 1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(STREAM_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(1);
    localparam logic [CW-1:0] LAT_LAST    = CW'(READ_LAT - 1);
    localparam logic [AW-1:0] RD_LAST     = AW'(READ_LEN - 1);
    localparam bit            NO_READS    = (READ_LEN == 0);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST,
        S_KLOAD,
        S_STREAM,
        S_DRAIN,
        S_RADDR,
        S_RWAIT,
        S_RHOLD,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          rd_cnt_q, rd_cnt_d;
    logic [RAM_WIDTH-1:0]   data_q, data_d;
    logic [GPIO_D-1:0]      gpio_q, gpio_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cap;

    assign cap = (state_q == S_RWAIT) && (cnt_q == LAT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        rd_cnt_d = rd_cnt_q;
        data_d   = data_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_start) state_d = S_RST;
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_KLOAD;
                end
            end
            S_KLOAD: begin
                if (cnt_q == KLOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d    = '0;
                    rd_cnt_d = '0;
                    state_d  = NO_READS ? S_DONE : S_RADDR;
                end
            end
            S_RADDR: begin
                cnt_d   = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (cap) begin
                    cnt_d   = '0;
                    data_d  = i_gpio_i[RAM_WIDTH-1:0];
                    state_d = S_RHOLD;
                end
            end
            S_RHOLD: begin
                cnt_d = '0;
                if (i_ready) begin
                    rd_cnt_d = rd_cnt_q + AW'(1);
                    state_d  = (rd_cnt_q == RD_LAST) ? S_DONE : S_RADDR;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change cleanly on the edge.
    always_comb begin
        gpio_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        unique case (state_d)
            S_IDLE:   busy_d = 1'b0;
            S_RST:    gpio_d[0] = 1'b1;
            S_KLOAD:  gpio_d[2] = 1'b1;
            S_STREAM: gpio_d[4:1] = 4'b1111;
            S_DRAIN:  gpio_d[1] = 1'b1;
            S_RADDR, S_RWAIT, S_RHOLD: begin
                gpio_d[1] = 1'b1;
                gpio_d[NB_ADDRESS+7:8] = rd_cnt_d[NB_ADDRESS-1:0];
                valid_d = (state_d == S_RHOLD);
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_cnt_q <= '0;
            data_q   <= '0;
            gpio_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            data_q   <= data_d;
            gpio_q   <= gpio_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_gpio_o = gpio_q;
    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

`ifdef HOST_SEQ_FMT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && i_start) err_d = 1'b0;
        if (cap && (|i_gpio_i[GPIO_D-1:RAM_WIDTH])) err_d = 1'b1;
    end

    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign o_err = err_q;
`else
    logic unused_hi;
    assign unused_hi = ^i_gpio_i[GPIO_D-1:RAM_WIDTH];
    assign o_err     = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_host_seq.sv
// Bench for gpio_host_seq: control schedule, scoreboarded readback, backpressure,
// start filtering, READ_LEN=0 and the optional readback format check.
module tb_gpio_host_seq;

`ifdef HOST_SEQ_FMT_CHECK_EN
    localparam bit FMT = 1'b1;
`else
    localparam bit FMT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] gpio_o, gpio_i, gpio_o2;
    logic [31:0] zero32 = '0;
    logic [12:0] data, data2;
    logic        valid, busy, done, err;
    logic        valid2, busy2, done2, err2;
    logic [9:0]  a1 = '0;
    logic [9:0]  a2 = '0;
    bit          fmt_mode = 1'b0;
    int          cyc = 0;
    int          t0 = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        a1  <= gpio_o[17:8];
        a2  <= a1;
    end

    always_comb begin
        gpio_i = 32'h100 + {22'b0, a2};
        if (fmt_mode && a2 == 10'd7) gpio_i = 32'h0008_0003;
    end

    gpio_host_seq dut (
        .CLK100MHZ(clk), .i_reset(rst_n), .i_start(start),
        .o_gpio_o(gpio_o), .i_gpio_i(gpio_i),
        .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    gpio_host_seq #(.READ_LEN(0)) dut0 (
        .CLK100MHZ(clk), .i_reset(rst_n), .i_start(start2),
        .o_gpio_o(gpio_o2), .i_gpio_i(zero32),
        .o_data(data2), .o_valid(valid2), .i_ready(1'b1),
        .o_busy(busy2), .o_done(done2), .o_err(err2)
    );

    function automatic int now_c();
        return cyc - t0;
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (gpio_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_gpio: got %h want 0", gpio_o);
        end
        n_checks++;
        if ({valid, busy, done, err} !== 4'b0) begin
            n_fail++; $display("FAIL rst_flags: got %b want 0000", {valid, busy, done, err});
        end
        n_checks++;
        if (data !== 13'h0) begin
            n_fail++; $display("FAIL rst_data: got %h want 0", data);
        end
        pulse_start();
        repeat (19) @(posedge clk);
        #1;
        n_checks++;
        if (gpio_o !== 32'h1E) begin
            n_fail++; $display("FAIL mid_stream_gpio: got %h want 1e", gpio_o);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gpio_o !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got gpio %h valid %b busy %b want 0", gpio_o, valid, busy);
        end
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || gpio_o !== 32'h0) begin
            n_fail++; $display("FAIL post_rst_idle: got busy %b gpio %h want 0", busy, gpio_o);
        end
    endtask

    task automatic test_control();
        logic [31:0] e;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(13'h100 + 13'(i));
        pulse_start();
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (c <= 4)       e = 32'h1;
            else if (c <= 7)  e = 32'h4;
            else if (c <= 45) e = 32'h1E;
            else              e = 32'h2;
            n_checks++;
            if (gpio_o !== e) begin
                n_fail++; $display("FAIL ctrl_c%0d: got %h want %h", now_c(), gpio_o, e);
            end
            if (c == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL busy_c1: got %b want 1", busy);
                end
            end
        end
    endtask

    task automatic test_readback();
        int words = 0;
        int first = -1;
        bit fin = 1'b0;
        logic [12:0] e;
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk);
            if (valid && first < 0) first = now_c();
            if (valid && ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rb_sb_empty: got %h want none", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        n_fail++; $display("FAIL rb_word%0d: got %h want %h", words, data, e);
                    end
                end
                words++;
            end
            if (done) begin
                fin = 1'b1;
                n_checks++;
                if (now_c() !== 176) begin
                    n_fail++; $display("FAIL rb_done_cycle: got %0d want 176", now_c());
                end
                n_checks++;
                if (first !== 51) begin
                    n_fail++; $display("FAIL rb_first_valid: got %0d want 51", first);
                end
                n_checks++;
                if (words !== 32 || busy !== 1'b0 || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rb_end: got words %0d busy %b err %b want 32 0 0", words, busy, err);
                end
            end
        end
        if (!fin) begin
            n_checks++; n_fail++; $display("FAIL rb_timeout: got no done want done");
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL start_at_done: got busy %b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int words = 0;
        int stall = 0;
        bit stalled = 1'b0;
        bit fin = 1'b0;
        logic [12:0] e;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(13'h100 + 13'(i));
        pulse_start();
        for (int k = 0; k < 400 && !fin; k++) begin
            @(negedge clk);
            if (valid && words == 5 && !stalled) begin
                stalled = 1'b1;
                stall = 10;
            end
            if (stall > 0) begin
                ready = 1'b0;
                stall--;
                n_checks++;
                if (data !== 13'h105 || valid !== 1'b1 || gpio_o[17:8] !== 10'd5) begin
                    n_fail++;
                    $display("FAIL bp_hold: got data %h valid %b addr %0d want 105 1 5",
                             data, valid, gpio_o[17:8]);
                end
            end else begin
                ready = 1'b1;
            end
            if (valid && ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_sb_empty: got %h want none", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        n_fail++; $display("FAIL bp_word%0d: got %h want %h", words, data, e);
                    end
                end
                words++;
            end
            if (done) begin
                fin = 1'b1;
                n_checks++;
                if (now_c() !== 186 || words !== 32 || exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL bp_end: got cycle %0d words %0d want 186 32", now_c(), words);
                end
            end
        end
        ready = 1'b1;
        if (!fin) begin
            n_checks++; n_fail++; $display("FAIL bp_timeout: got no done want done");
        end
    endtask

    task automatic test_start_busy();
        int words = 0;
        bit fin = 1'b0;
        logic [12:0] e;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(13'h100 + 13'(i));
        pulse_start();
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk);
            start = (now_c() == 20 || now_c() == 100);
            if (valid && ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1FFF;
                if (data !== e) begin
                    n_fail++; $display("FAIL sb_word%0d: got %h want %h", words, data, e);
                end
                words++;
            end
            if (done) begin
                fin = 1'b1;
                n_checks++;
                if (now_c() !== 176 || words !== 32) begin
                    n_fail++;
                    $display("FAIL sb_end: got cycle %0d words %0d want 176 32", now_c(), words);
                end
            end
        end
        start = 1'b0;
        if (!fin) begin
            n_checks++; n_fail++; $display("FAIL sb_timeout: got no done want done");
        end
    endtask

    task automatic test_read_len0();
        bit saw_valid = 1'b0;
        bit fin = 1'b0;
        @(posedge clk);
        #1 start2 = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk);
            if (valid2) saw_valid = 1'b1;
            if (done2) begin
                fin = 1'b1;
                n_checks++;
                if (now_c() !== 48 || gpio_o2 !== 32'h0 || busy2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rl0_done: got cycle %0d gpio %h busy %b want 48 0 0",
                             now_c(), gpio_o2, busy2);
                end
            end
        end
        n_checks++;
        if (!fin || saw_valid) begin
            n_fail++; $display("FAIL rl0_flow: got done %b valid %b want 1 0", fin, saw_valid);
        end
    endtask

    task automatic test_fmt_check();
        int words = 0;
        bit fin = 1'b0;
        logic [12:0] e;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back((i == 7) ? 13'h3 : 13'h100 + 13'(i));
        fmt_mode = 1'b1;
        pulse_start();
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk);
            if (valid && ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1FFF;
                if (data !== e) begin
                    n_fail++; $display("FAIL fmt_word%0d: got %h want %h", words, data, e);
                end
                if (words == 6 || words == 7) begin
                    n_checks++;
                    if (err !== ((words == 7) ? FMT : 1'b0)) begin
                        n_fail++; $display("FAIL fmt_err_w%0d: got %b want %b", words, err,
                                           (words == 7) ? FMT : 1'b0);
                    end
                end
                words++;
            end
            if (done) begin
                fin = 1'b1;
                n_checks++;
                if (err !== FMT || now_c() !== 176) begin
                    n_fail++;
                    $display("FAIL fmt_done: got err %b cycle %0d want %b 176", err, now_c(), FMT);
                end
            end
        end
        if (!fin) begin
            n_checks++; n_fail++; $display("FAIL fmt_timeout: got no done want done");
        end
        fmt_mode = 1'b0;
        pulse_start();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fmt_clear: got err %b busy %b want 0 1", err, busy);
        end
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_control();
        test_readback();
        test_backpressure();
        test_start_busy();
        test_read_len0();
        test_fmt_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
